// File: rtl/video_timing.sv
// Raster timing generator: horizontal/vertical counters plus sync, visible
// and line/frame markers for one VGA mode (default 640x480@60).
// Every output is registered from the next-state counters, so all outputs
// line up with the counter values shown in the same cycle.
module video_timing #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int CNT_W      = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pixel_en_i,
   output logic [CNT_W-1:0] h_count_o,
   output logic [CNT_W-1:0] v_count_o,
   output logic             visible_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             line_start_o,
   output logic             frame_start_o
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Inclusive bounds; a total may equal 2**CNT_W, so only "last" values are
   // guaranteed to fit in CNT_W bits.
   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VISIBLE - 1);
   localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
   localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic visible_q, visible_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;

   // Next counter position and the outputs decoded from it; reset wins.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pixel_en_i) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
      if (reset) begin
         h_d = H_LAST;
         v_d = V_LAST;
      end

      visible_d     = (h_d <= H_VIS_LAST) && (v_d <= V_VIS_LAST);
      hsync_d       = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d       = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);

      if (reset) begin
         visible_d     = 1'b0;
         hsync_d       = ~H_SYNC_POL;
         vsync_d       = ~V_SYNC_POL;
         line_start_d  = 1'b0;
         frame_start_d = 1'b0;
      end
   end

   // Counter and output registers; the decode above already handles hold.
   always_ff @(posedge clk) begin
      h_q           <= h_d;
      v_q           <= v_d;
      visible_q     <= visible_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
   end

   assign h_count_o     = h_q;
   assign v_count_o     = v_q;
   assign visible_o     = visible_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default 640x480 instance and a tiny
// positive-polarity mode (16x11 total) for whole-frame and mid-frame checks.
module tb_video_timing;

   typedef struct {
      logic [31:0] h, v, vis, hs, vs, ls, fs;
   } smp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, en0, rst1, en1;
   logic [9:0] h0, v0;
   logic [4:0] h1, v1;
   logic vis0, hs0, vs0, ls0, fs0;
   logic vis1, hs1, vs1, ls1, fs1;

   video_timing d0 (
      .clk(clk), .reset(rst0), .pixel_en_i(en0),
      .h_count_o(h0), .v_count_o(v0), .visible_o(vis0),
      .hsync_o(hs0), .vsync_o(vs0), .line_start_o(ls0), .frame_start_o(fs0)
   );

   video_timing #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(5)
   ) d1 (
      .clk(clk), .reset(rst1), .pixel_en_i(en1),
      .h_count_o(h1), .v_count_o(v1), .visible_o(vis1),
      .hsync_o(hs1), .vsync_o(vs1), .line_start_o(ls1), .frame_start_o(fs1)
   );

   int n_tot = 0;
   int n_bad = 0;
   smp_t sb[$];
   int mh[2], mv[2];
   int n_hs, n_vs, n_vis, n_ls, n_fs;
   logic p_ls, p_fs;

   function automatic int ht(input int s); return (s == 0) ? 800 : 16; endfunction
   function automatic int vt(input int s); return (s == 0) ? 525 : 11; endfunction
   function automatic int hpol(input int s); return (s == 0) ? 0 : 1; endfunction

   // Reference decode of one raster position.
   function automatic smp_t dec(input int s, input int h, input int v);
      smp_t d;
      int hv, hf, hw, vv, vf, vw, hp;
      hv = (s == 0) ? 640 : 8;  hf = (s == 0) ? 16 : 2;  hw = (s == 0) ? 96 : 3;
      vv = (s == 0) ? 480 : 6;  vf = (s == 0) ? 10 : 1;  vw = 2;
      hp = hpol(s);
      d.h   = h;
      d.v   = v;
      d.vis = (h < hv && v < vv) ? 1 : 0;
      d.hs  = (h >= hv + hf && h < hv + hf + hw) ? hp : 1 - hp;
      d.vs  = (v >= vv + vf && v < vv + vf + vw) ? hp : 1 - hp;
      d.ls  = (h == 0) ? 1 : 0;
      d.fs  = (h == 0 && v == 0) ? 1 : 0;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr();
      n_hs = 0; n_vs = 0; n_vis = 0; n_ls = 0; n_fs = 0;
   endtask

   // One clock on instance s: drive, push expectation, then pop and compare.
   task automatic cyc(input int s, input bit r, input bit e);
      smp_t x, a;
      if (s == 0) begin rst0 = r; en0 = e; end
      else        begin rst1 = r; en1 = e; end
      if (r) begin
         mh[s] = ht(s) - 1;
         mv[s] = vt(s) - 1;
      end else if (e) begin
         if (mh[s] == ht(s) - 1) begin
            mh[s] = 0;
            mv[s] = (mv[s] == vt(s) - 1) ? 0 : mv[s] + 1;
         end else begin
            mh[s] = mh[s] + 1;
         end
      end
      x = dec(s, mh[s], mv[s]);
      if (r) begin
         x.vis = 0; x.ls = 0; x.fs = 0;
         x.hs = 1 - hpol(s); x.vs = 1 - hpol(s);
      end
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      if (s == 0) begin
         a.h = 32'(h0); a.v = 32'(v0); a.vis = 32'(vis0); a.hs = 32'(hs0);
         a.vs = 32'(vs0); a.ls = 32'(ls0); a.fs = 32'(fs0);
      end else begin
         a.h = 32'(h1); a.v = 32'(v1); a.vis = 32'(vis1); a.hs = 32'(hs1);
         a.vs = 32'(vs1); a.ls = 32'(ls1); a.fs = 32'(fs1);
      end
      chk("h_count", a.h, x.h);
      chk("v_count", a.v, x.v);
      chk("visible", a.vis, x.vis);
      chk("hsync", a.hs, x.hs);
      chk("vsync", a.vs, x.vs);
      chk("line_start", a.ls, x.ls);
      chk("frame_start", a.fs, x.fs);
      if (a.hs == 32'(hpol(s))) n_hs++;
      if (a.vs == 32'(hpol(s))) n_vs++;
      if (a.vis == 1) n_vis++;
      if (a.ls == 1 && !p_ls) n_ls++;
      if (a.fs == 1 && !p_fs) n_fs++;
      p_ls = a.ls[0];
      p_fs = a.fs[0];
   endtask

   initial begin
      rst0 = 1'b1; en0 = 1'b0; rst1 = 1'b1; en1 = 1'b0;
      p_ls = 1'b0; p_fs = 1'b0;
      mh[0] = 799; mv[0] = 524; mh[1] = 15; mv[1] = 10;
      clr();

      // Default mode: reset for 3 cycles (enable high, reset must win).
      for (int i = 0; i < 3; i++) cyc(0, 1'b1, (i == 2));
      chk("rst_h", 32'(h0), 799);
      chk("rst_v", 32'(v0), 524);
      chk("rst_hs_inactive", 32'(hs0), 1);
      cyc(0, 1'b0, 1'b1);
      chk("first_en_fs", 32'(fs0), 1);
      chk("first_en_h", 32'(h0), 0);

      // One full line from (0,0).
      clr();
      for (int i = 0; i < 800; i++) cyc(0, 1'b0, 1'b1);
      chk("line_hs_width", n_hs, 96);
      chk("line_visible", n_vis, 640);
      chk("line_end_v", 32'(v0), 1);
      chk("line_end_h", 32'(h0), 0);

      // Enable every other cycle: hsync stretches to 192 clocks.
      clr();
      for (int i = 0; i < 1600; i++) cyc(0, 1'b0, i[0]);
      chk("half_rate_hs_width", n_hs, 192);
      chk("half_rate_end_v", 32'(v0), 2);

      // Mid-line reset at h=300, then resume.
      for (int i = 0; i < 300; i++) cyc(0, 1'b0, 1'b1);
      chk("pre_rst_h", 32'(h0), 300);
      cyc(0, 1'b1, 1'b1);
      chk("mid_rst_h", 32'(h0), 799);
      cyc(0, 1'b0, 1'b0);
      cyc(0, 1'b0, 1'b1);
      chk("resume_fs", 32'(fs0), 1);
      rst0 = 1'b1;

      // Tiny positive-polarity mode: reset, then one whole frame.
      p_ls = 1'b0; p_fs = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1, 1'b1, 1'b0);
      chk("pos_rst_hs", 32'(hs1), 0);
      chk("pos_rst_vs", 32'(vs1), 0);
      cyc(1, 1'b0, 1'b1);
      clr();
      for (int i = 0; i < 176; i++) cyc(1, 1'b0, 1'b1);
      chk("frame_fs_windows", n_fs, 1);
      chk("frame_ls_windows", n_ls, 11);
      chk("frame_vs_clocks", n_vs, 32);
      chk("frame_hs_clocks", n_hs, 33);
      chk("frame_end_h", 32'(h1), 0);
      chk("frame_end_v", 32'(v1), 0);

      // Mid-frame reset at (5,3), with enable high.
      for (int i = 0; i < 3 * 16 + 5; i++) cyc(1, 1'b0, 1'b1);
      chk("pre_rst_pos", {16'(h1), 16'(v1)}, {16'd5, 16'd3});
      cyc(1, 1'b1, 1'b1);
      chk("mf_rst_h", 32'(h1), 15);
      chk("mf_rst_v", 32'(v1), 10);
      cyc(1, 1'b0, 1'b1);
      chk("mf_resume_fs", 32'(fs1), 1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
